// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a five-stage pipeline (F, D, E, M, W).
// It decides each cycle whether the pipeline advances. When it advances, the
// controller also chooses which pipeline registers load and which ones load a
// bubble. A small state machine tracks a data-memory wait and core halt.
//
// Optional feature (macro HAZARD_PERF_EN):
//   When defined, stall_cnt is a saturating 32-bit count of stall cycles.
//   When undefined, stall_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   CLK         in   1  clock, rising edge
//   RST         in   1  synchronous, active-high reset
//   ihit        in   1  instruction fetch complete
//   dhit        in   1  data access complete
//   dmem_req    in   1  load/store sitting in the EX/MEM register
//   ex_memread  in   1  load sitting in the DE/EX register
//   ex_wsel     in   5  DE/EX destination register
//   id_rs       in   5  decode-stage source register rs
//   id_rt       in   5  decode-stage source register rt
//   br_taken    in   1  taken branch resolved in MEM
//   jump_id     in   1  jump in decode
//   halt_mem    in   1  halt sitting in the EX/MEM register
//   pc_en       out  1  PC update enable
//   fd_en       out  1  F/D register load enable
//   de_en       out  1  D/E register load enable
//   em_en       out  1  E/M register load enable
//   mw_en       out  1  M/W register load enable
//   fd_flush    out  1  F/D loads a bubble
//   de_flush    out  1  D/E loads a bubble
//   em_flush    out  1  E/M loads a bubble
//   halted      out  1  core stopped
//   stall_cnt   out 32  stall cycle count (zero unless HAZARD_PERF_EN)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmem_req,
    input  logic        ex_memread,
    input  logic [4:0]  ex_wsel,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        br_taken,
    input  logic        jump_id,
    input  logic        halt_mem,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        mw_en,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        halted,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    logic adv;
    logic load_use;
    logic enter_halt;

    // The pipeline advances only when both the fetch and any outstanding
    // data access are complete. While waiting on data memory, the fetch
    // result is irrelevant: the frozen pipeline re-presents the same fetch.
    always_comb begin
        adv = 1'b0;
        case (state)
            RUN:     adv = ihit & (~dmem_req | dhit);
            DWAIT:   adv = dhit;
            default: adv = 1'b0;
        endcase
    end

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    assign load_use = ex_memread && (ex_wsel != 5'd0) &&
                      ((ex_wsel == id_rs) || (ex_wsel == id_rt));

    // A halt that arrives together with a taken branch is on the wrong path.
    // Only the branch takes effect.
    assign enter_halt = halt_mem & adv & ~br_taken;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (enter_halt)
                        state <= HALT;
                    else if (dmem_req && !dhit)
                        state <= DWAIT;
                end
                DWAIT: begin
                    if (enter_halt)
                        state <= HALT;
                    else if (dhit)
                        state <= RUN;
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    // Enable and flush decision
    // Priority: freeze > branch > load-use > jump > normal advance.
    // A load-use stall holds PC and F/D, so the jump in decode is seen
    // again on the next cycle.
    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        mw_en    = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        halted   = 1'b0;

        if (RST) begin
            // All outputs stay at zero during reset.
        end else if (state == HALT) begin
            halted = 1'b1;
        end else if (adv) begin
            if (br_taken) begin
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                de_en    = 1'b1;
                em_en    = 1'b1;
                mw_en    = 1'b1;
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
            end else if (load_use) begin
                de_en    = 1'b1;
                em_en    = 1'b1;
                mw_en    = 1'b1;
                de_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                de_en    = 1'b1;
                em_en    = 1'b1;
                mw_en    = 1'b1;
                fd_flush = jump_id;
            end
        end
    end

    // Optional stall counter
`ifdef HAZARD_PERF_EN
    logic        stall_event;
    logic [31:0] stall_q;

    // A stall is either a full freeze or a load-use bubble. A load-use match
    // that the branch overrides is not a stall.
    assign stall_event = (state != HALT) &&
                         (!adv || (load_use && !br_taken));

    always_ff @(posedge CLK) begin
        if (RST)
            stall_q <= '0;
        else if (stall_event && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = RST ? '0 : stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam int unsigned PERF = 1;
`else
    localparam int unsigned PERF = 0;
`endif

    // Expected output vector: {pc,fd,de,em,mw, fdf,def,emf, halted}
    localparam logic [8:0] V_ZERO = 9'b00000_000_0;
    localparam logic [8:0] V_RUN  = 9'b11111_000_0;
    localparam logic [8:0] V_LU   = 9'b00111_010_0;
    localparam logic [8:0] V_BR   = 9'b11111_111_0;
    localparam logic [8:0] V_JMP  = 9'b11111_100_0;
    localparam logic [8:0] V_HALT = 9'b00000_000_1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dmem_req, ex_memread;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        br_taken, jump_id, halt_mem;
    logic        pc_en, fd_en, de_en, em_en, mw_en;
    logic        fd_flush, de_flush, em_flush, halted;
    logic [31:0] stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_sc   = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .dmem_req   (dmem_req),
        .ex_memread (ex_memread),
        .ex_wsel    (ex_wsel),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .br_taken   (br_taken),
        .jump_id    (jump_id),
        .halt_mem   (halt_mem),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .de_en      (de_en),
        .em_en      (em_en),
        .mw_en      (mw_en),
        .fd_flush   (fd_flush),
        .de_flush   (de_flush),
        .em_flush   (em_flush),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    task automatic idle_inputs();
        ihit       = 1'b0;
        dhit       = 1'b0;
        dmem_req   = 1'b0;
        ex_memread = 1'b0;
        ex_wsel    = 5'd0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        br_taken   = 1'b0;
        jump_id    = 1'b0;
        halt_mem   = 1'b0;
    endtask

    // Check the current cycle at the falling edge, then move to just after
    // the next rising edge. 'stall' tells the model that this cycle counts.
    task automatic step(input string tag, input logic [8:0] exp_v, input bit stall);
        logic [8:0]  obs_v;
        logic [31:0] exp_cnt;
        @(negedge CLK);
        obs_v   = {pc_en, fd_en, de_en, em_en, mw_en,
                   fd_flush, de_flush, em_flush, halted};
        exp_cnt = (PERF != 0 && !RST) ? exp_sc : 32'd0;
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed outputs %b expected %b", tag, obs_v, exp_v);
        end
        n_checks++;
        assert (stall_cnt === exp_cnt) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, exp_cnt);
        end
        if (RST)
            exp_sc = 0;
        else if (stall)
            exp_sc++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle_inputs();
        ihit = 1'b1;
        RST  = 1'b1;
        step("reset_c0", V_ZERO, 0);
        step("reset_c1", V_ZERO, 0);
        RST = 1'b0;

        // Normal advance after reset
        step("run_normal", V_RUN, 0);

        // Data miss: one RUN cycle plus two DWAIT cycles, then dhit
        dmem_req = 1'b1;
        step("dmiss_c0", V_ZERO, 1);
        step("dmiss_c1", V_ZERO, 1);
        dmem_req = 1'b0;
        step("dwait_ignores_ihit", V_ZERO, 1);
        ihit     = 1'b0;
        dmem_req = 1'b1;
        dhit     = 1'b1;
        step("dwait_dhit_adv", V_RUN, 0);
        dmem_req = 1'b0;
        dhit     = 1'b0;
        step("back_in_run_needs_ihit", V_ZERO, 1);
        ihit = 1'b1;
        step("run_again", V_RUN, 0);

        // Load-use on rt, repeated, then on rs
        ex_memread = 1'b1;
        ex_wsel    = 5'd5;
        id_rt      = 5'd5;
        step("lu_rt_c0", V_LU, 1);
        step("lu_rt_c1", V_LU, 1);
        ex_wsel = 5'd0;
        id_rt   = 5'd0;
        step("lu_r0_no_stall", V_RUN, 0);
        ex_wsel = 5'd7;
        id_rs   = 5'd7;
        step("lu_rs", V_LU, 1);
        ex_memread = 1'b0;
        step("no_memread_no_stall", V_RUN, 0);

        // Jumps
        jump_id = 1'b1;
        step("jump", V_JMP, 0);
        ex_memread = 1'b1;
        step("lu_over_jump", V_LU, 1);
        ex_memread = 1'b0;
        step("jump_retry", V_JMP, 0);

        // Branch overrides load-use and jump
        ex_memread = 1'b1;
        br_taken   = 1'b1;
        step("branch_override", V_BR, 0);
        idle_inputs();
        ihit = 1'b1;

        // Branch together with halt: branch only
        br_taken = 1'b1;
        halt_mem = 1'b1;
        step("branch_and_halt", V_BR, 0);
        br_taken = 1'b0;
        halt_mem = 1'b0;
        step("not_halted_after_branch", V_RUN, 0);

        // Halt without advance does not halt
        ihit     = 1'b0;
        halt_mem = 1'b1;
        step("halt_frozen", V_ZERO, 1);
        ihit     = 1'b1;
        halt_mem = 1'b0;
        step("not_halted_after_freeze", V_RUN, 0);

        // Real halt
        halt_mem = 1'b1;
        step("halt_advances", V_RUN, 0);
        halt_mem = 1'b0;
        dhit     = 1'b1;
        for (int i = 0; i < 10; i++)
            step($sformatf("halted_%0d", i), V_HALT, 0);

        // Reset leaves HALT
        RST = 1'b1;
        step("reset_from_halt", V_ZERO, 0);
        RST  = 1'b0;
        dhit = 1'b0;
        step("run_after_reset", V_RUN, 0);
        ihit = 1'b0;
        step("post_reset_freeze", V_ZERO, 1);
        ihit = 1'b1;
        step("post_reset_count", V_RUN, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock, CLK (input, 1), rising-edge only.
REQ-002 The block SHALL have reset RST (input, 1), synchronous and active-high.
REQ-003 Inputs SHALL be:
- ihit (1): instruction fetch complete.
- dhit (1): data access complete.
- dmem_req (1): load/store in the EX/MEM register.
- ex_memread (1): load in the DE/EX register.
- ex_wsel (5): DE/EX destination register.
- id_rs (5), id_rt (5): decode-stage sources.
- br_taken (1): taken branch resolved in MEM.
- jump_id (1): jump in decode.
- halt_mem (1): halt in the EX/MEM register.
REQ-004 Outputs SHALL be:
- pc_en (1): PC update.
- fd_en, de_en, em_en, mw_en (1 each): pipeline-register load enables.
- fd_flush, de_flush, em_flush (1 each): load-a-bubble.
- halted (1): core stopped.
- stall_cnt (32): stall count.

Function
REQ-005 The block SHALL hold a state register with states RUN, DWAIT and HALT; all other outputs SHALL be combinational from state and inputs.
REQ-006 adv SHALL be ihit & (~dmem_req | dhit) in RUN, dhit in DWAIT, and 0 in HALT.
REQ-007 In RUN, dmem_req & ~dhit SHALL move the state to DWAIT next cycle, with adv=0 this cycle.
REQ-008 In DWAIT, dhit SHALL return the state to RUN next cycle; ihit SHALL be ignored in DWAIT.
REQ-009 With adv=0, pc_en and all *_en and *_flush outputs SHALL be 0 (full freeze).
REQ-010 With adv=1 and no hazard, pc_en and all four *_en SHALL be 1, and all *_flush SHALL be 0.
REQ-011 Load-use SHALL be defined as ex_memread & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt).
REQ-012 Load-use with adv=1 SHALL give pc_en=0, fd_en=0, de_en=1, de_flush=1, em_en=1, mw_en=1 (one bubble per cycle while the condition holds).
REQ-013 br_taken with adv=1 SHALL give fd_flush=de_flush=em_flush=1 with all enables 1, and SHALL override load-use and jump.
REQ-014 jump_id with adv=1, no br_taken and no load-use SHALL give fd_flush=1 only.
REQ-015 Load-use SHALL take priority over jump_id, and the jump SHALL be re-evaluated next cycle.
REQ-016 A *_flush output SHALL never be 1 while its matching *_en is 0.
REQ-017 halt_mem & adv & ~br_taken SHALL move the state to HALT next cycle; that cycle SHALL advance normally so the halt reaches MEM/WB.
REQ-018 In HALT, halted SHALL be 1 and all enables SHALL be 0; HALT SHALL be left only by RST.
REQ-019 br_taken & halt_mem in the same cycle SHALL be treated as a branch only.
REQ-020 Latency: a decision SHALL apply in the same cycle as its inputs, and state changes SHALL take effect on the next CLK edge.

Reset
REQ-021 RST=1 at a CLK edge SHALL set state=RUN and stall_cnt=0, and SHALL abort DWAIT/HALT.
REQ-022 While RST=1, all outputs SHALL be 0.
REQ-023 The first cycle after RST deasserts SHALL follow the RUN rules.

Configuration
REQ-024 With macro HAZARD_PERF_EN defined, stall_cnt SHALL increment in RUN/DWAIT on each cycle where adv=0 or load-use is stalling, and SHALL saturate at 32'hFFFF_FFFF.
REQ-025 Without HAZARD_PERF_EN, stall_cnt SHALL be constant 0 with no counter flops; all other behaviour SHALL be identical.

Verification
REQ-026 Bench SHALL cover: RST high 2 cycles, then ihit=1, no hazards -> pc_en, fd_en, de_en, em_en, mw_en all 1, flushes 0, halted 0.
REQ-027 Bench SHALL cover: dmem_req=1, dhit=0 for 3 cycles then dhit=1 -> enables 0 for 3 cycles, state DWAIT, all enables 1 on the dhit cycle, RUN next; stall_cnt=3 with HAZARD_PERF_EN.
REQ-028 Bench SHALL cover: ex_memread=1, ex_wsel=5, id_rt=5, ihit=1 -> pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1; repeat with ex_wsel=0 -> no stall.
REQ-029 Bench SHALL cover: br_taken=1 with jump_id=1 and a load-use match -> fd_flush=de_flush=em_flush=1, all enables 1.
REQ-030 Bench SHALL cover: halt_mem=1, ihit=1 -> advance that cycle, then halted=1 and enables 0 for 10 cycles; RST=1 -> halted=0, state RUN.
